inst_fetcher: RTL and testbench

Front-end sequencer that owns the program counter and drives the decoder's `IFDC_*` input bundle. It fetches one instruction at a time from the instruction cache when the decoder forwards the dispatcher's request (`DCIF_ask_IF`). It predicts the next PC using static jal targets and a 2-bit branch history table (BHT), and stalls on jalr until the target resolves. It redirects on a ROB flush.

---
 rtl/inst_fetcher_if.sv | 47 ++++
 rtl/inst_fetcher.sv | 157 +++++++++++++++
 tb/tb_inst_fetcher.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetcher_if.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetcher_if
// Brief    : Fetcher bundle: dispatcher ask, icache request/response,
//            decoder outputs and ROB redirect/update inputs.
// Revision : 1.0 - initial release
// ============================================================================
interface inst_fetcher_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  DCIF_ask_IF;
  logic                  IFIC_en;
  logic [ADDR_WIDTH-1:0] IFIC_addr;
  logic                  ICIF_en;
  logic [31:0]           ICIF_data;
  logic                  IFDC_en;
  logic [ADDR_WIDTH-1:0] IFDC_pc;
  logic [6:0]            IFDC_opcode;
  logic [24:0]           IFDC_remain_inst;
  logic                  IFDC_predict_result;
  logic                  ROBIF_flush;
  logic [ADDR_WIDTH-1:0] ROBIF_target_pc;
  logic                  ROBIF_jalr_en;
  logic [ADDR_WIDTH-1:0] ROBIF_jalr_pc;
  logic                  ROBIF_br_en;
  logic [ADDR_WIDTH-1:0] ROBIF_br_pc;
  logic                  ROBIF_br_taken;

  modport master (
    input  DCIF_ask_IF,
    output IFIC_en, IFIC_addr,
    input  ICIF_en, ICIF_data,
    output IFDC_en, IFDC_pc, IFDC_opcode, IFDC_remain_inst, IFDC_predict_result,
    input  ROBIF_flush, ROBIF_target_pc, ROBIF_jalr_en, ROBIF_jalr_pc,
    input  ROBIF_br_en, ROBIF_br_pc, ROBIF_br_taken
  );

  modport slave (
    output DCIF_ask_IF,
    input  IFIC_en, IFIC_addr,
    output ICIF_en, ICIF_data,
    input  IFDC_en, IFDC_pc, IFDC_opcode, IFDC_remain_inst, IFDC_predict_result,
    output ROBIF_flush, ROBIF_target_pc, ROBIF_jalr_en, ROBIF_jalr_pc,
    output ROBIF_br_en, ROBIF_br_pc, ROBIF_br_taken
  );
endinterface
`default_nettype wire

// File: rtl/inst_fetcher.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetcher
// Brief    : PC owner; fetches one instruction at a time, predicts next PC
//            (static jal, 2-bit BHT for branches), stalls on jalr.
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetcher #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    BHT_BITS   = 6
) (
  input  wire logic       clk_in,
  input  wire logic       rst_in,
  input  wire logic       rdy_in,
  inst_fetcher_if.master  bus
);

  localparam int                    c_BHT_SIZE = 1 << BHT_BITS;
  localparam logic [6:0]            c_OP_JAL   = 7'b1101111;
  localparam logic [6:0]            c_OP_BR    = 7'b1100011;
  localparam logic [6:0]            c_OP_JALR  = 7'b1100111;
  localparam logic [ADDR_WIDTH-1:0] c_PC_STEP  = ADDR_WIDTH'(4);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_FETCH     = 2'd1,
    S_WAIT_JALR = 2'd2
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_pc, w_pc_nxt;
  logic [1:0]            r_bht [c_BHT_SIZE];

  logic                  r_ific_en;
  logic [ADDR_WIDTH-1:0] r_ific_addr;
  logic                  r_ifdc_en;
  logic [ADDR_WIDTH-1:0] r_ifdc_pc;
  logic [6:0]            r_ifdc_opcode;
  logic [24:0]           r_ifdc_remain;
  logic                  r_ifdc_pred;

  logic [31:0]           w_inst;
  logic [31:0]           w_imm_j, w_imm_b;
  logic [BHT_BITS-1:0]   w_lookup_idx, w_update_idx;
  logic                  w_bht_pred;
  logic                  w_pred_taken;
  logic                  w_fire;
  logic                  w_unused;

  assign w_inst       = bus.ICIF_data;
  assign w_imm_j      = {{12{w_inst[31]}}, w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};
  assign w_imm_b      = {{20{w_inst[31]}}, w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
  assign w_lookup_idx = r_pc[BHT_BITS+1:2];
  assign w_update_idx = bus.ROBIF_br_pc[BHT_BITS+1:2];
  assign w_bht_pred   = r_bht[w_lookup_idx][1];
  // A flush in the response cycle discards the returned word.
  assign w_fire       = (r_state == S_FETCH) && bus.ICIF_en && !bus.ROBIF_flush;
  assign w_unused     = ^{bus.ROBIF_br_pc[ADDR_WIDTH-1:BHT_BITS+2], bus.ROBIF_br_pc[1:0]};

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
    end else if (rdy_in) begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_pred_taken = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.DCIF_ask_IF) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (bus.ICIF_en) begin
          w_state_nxt = S_IDLE;
          case (w_inst[6:0])
            c_OP_JAL: begin
              w_pc_nxt     = r_pc + ADDR_WIDTH'($signed(w_imm_j));
              w_pred_taken = 1'b1;
            end
            c_OP_BR: begin
              w_pc_nxt     = w_bht_pred ? r_pc + ADDR_WIDTH'($signed(w_imm_b)) : r_pc + c_PC_STEP;
              w_pred_taken = w_bht_pred;
            end
            c_OP_JALR: w_state_nxt = S_WAIT_JALR;
            default:   w_pc_nxt    = r_pc + c_PC_STEP;
          endcase
        end
      end
      S_WAIT_JALR: begin
        if (bus.ROBIF_jalr_en) begin
          w_pc_nxt    = bus.ROBIF_jalr_pc;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (bus.ROBIF_flush) begin
      w_state_nxt = S_IDLE;
      w_pc_nxt    = bus.ROBIF_target_pc;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_ific_en     <= 1'b0;
      r_ific_addr   <= '0;
      r_ifdc_en     <= 1'b0;
      r_ifdc_pc     <= '0;
      r_ifdc_opcode <= '0;
      r_ifdc_remain <= '0;
      r_ifdc_pred   <= 1'b0;
    end else begin
      r_ifdc_en <= 1'b0;
      if (rdy_in) begin
        r_ific_en <= (w_state_nxt == S_FETCH);
        // Address is captured only on request launch, so it is stable while en is high.
        if (r_state == S_IDLE && w_state_nxt == S_FETCH) r_ific_addr <= r_pc;
        if (w_fire) begin
          r_ifdc_en     <= 1'b1;
          r_ifdc_pc     <= r_pc;
          r_ifdc_opcode <= w_inst[6:0];
          r_ifdc_remain <= w_inst[31:7];
          r_ifdc_pred   <= w_pred_taken;
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < c_BHT_SIZE; i++) r_bht[i] <= 2'b01;
    end else if (rdy_in && bus.ROBIF_br_en) begin
      if (bus.ROBIF_br_taken) begin
        if (r_bht[w_update_idx] != 2'b11) r_bht[w_update_idx] <= r_bht[w_update_idx] + 2'b01;
      end else begin
        if (r_bht[w_update_idx] != 2'b00) r_bht[w_update_idx] <= r_bht[w_update_idx] - 2'b01;
      end
    end
  end

  assign bus.IFIC_en             = r_ific_en;
  assign bus.IFIC_addr           = r_ific_addr;
  assign bus.IFDC_en             = r_ifdc_en;
  assign bus.IFDC_pc             = r_ifdc_pc;
  assign bus.IFDC_opcode         = r_ifdc_opcode;
  assign bus.IFDC_remain_inst    = r_ifdc_remain;
  assign bus.IFDC_predict_result = r_ifdc_pred;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetcher
// Brief    : Directed + randomized bench for inst_fetcher with a PC/BHT model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetcher;

  localparam int c_ALU  = 0;
  localparam int c_JAL  = 1;
  localparam int c_BR   = 2;
  localparam int c_JALR = 3;

  bit clk = 1'b0;
  bit rst = 1'b1;
  bit rdy = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_pc;
  int          m_bht [64];

  inst_fetcher_if #(.ADDR_WIDTH(32)) bus ();

  inst_fetcher #(
    .ADDR_WIDTH(32),
    .RESET_PC  (32'h0),
    .BHT_BITS  (6)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .rdy_in(rdy),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int bidx(input logic [31:0] p);
    return int'(p[7:2]);
  endfunction

  function automatic void model_reset();
    m_pc = 32'h0;
    for (int i = 0; i < 64; i++) m_bht[i] = 1;
  endfunction

  function automatic void model_bht(input logic [31:0] p, input bit taken);
    int i;
    i = bidx(p);
    if (taken) m_bht[i] = (m_bht[i] == 3) ? 3 : m_bht[i] + 1;
    else       m_bht[i] = (m_bht[i] == 0) ? 0 : m_bht[i] - 1;
  endfunction

  // Encodes an instruction of the given kind with a byte offset for jal/branch.
  function automatic logic [31:0] make_inst(input int kind, input int off, input logic [31:0] rnd);
    logic [31:0] o;
    o = off;
    case (kind)
      c_JAL:   return {o[20], o[10:1], o[11], o[19:12], rnd[11:7], 7'b1101111};
      c_BR:    return {o[12], o[10:5], rnd[24:20], rnd[19:15], rnd[14:12], o[4:1], o[11], 7'b1100011};
      c_JALR:  return {rnd[31:7], 7'b1100111};
      default: return {rnd[31:7], 7'b0010011};
    endcase
  endfunction

  task automatic wait_ific();
    int n;
    n = 0;
    while (bus.IFIC_en !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("ific_en_timeout", 32'(bus.IFIC_en), 32'd1);
  endtask

  task automatic do_fetch(input logic [31:0] inst, input int kind, input int off, input int lat,
                          input bit upd_same, input bit upd_taken);
    logic [31:0] a, nxt;
    bit          pred;
    wait_ific();
    check("ific_addr", bus.IFIC_addr, m_pc);
    a = bus.IFIC_addr;
    for (int i = 0; i < lat; i++) begin
      tick();
      check("ific_hold_en", 32'(bus.IFIC_en), 32'd1);
      check("ific_hold_addr", bus.IFIC_addr, a);
      check("ifdc_quiet", 32'(bus.IFDC_en), 32'd0);
    end
    pred = 1'b0;
    nxt  = m_pc + 32'd4;
    case (kind)
      c_JAL: begin
        pred = 1'b1;
        nxt  = m_pc + 32'(off);
      end
      c_BR: begin
        pred = (m_bht[bidx(m_pc)] >= 2);
        if (pred) nxt = m_pc + 32'(off);
      end
      c_JALR:  nxt = m_pc;
      default: ;
    endcase
    bus.ICIF_en   = 1'b1;
    bus.ICIF_data = inst;
    if (upd_same) begin
      bus.ROBIF_br_en    = 1'b1;
      bus.ROBIF_br_pc    = m_pc;
      bus.ROBIF_br_taken = upd_taken;
      model_bht(m_pc, upd_taken);
    end
    tick();
    bus.ICIF_en     = 1'b0;
    bus.ICIF_data   = $urandom;
    bus.ROBIF_br_en = 1'b0;
    check("ifdc_en", 32'(bus.IFDC_en), 32'd1);
    check("ifdc_pc", bus.IFDC_pc, m_pc);
    check("ifdc_opcode", 32'(bus.IFDC_opcode), 32'(inst[6:0]));
    check("ifdc_remain", 32'(bus.IFDC_remain_inst), 32'(inst[31:7]));
    check("ifdc_predict", 32'(bus.IFDC_predict_result), 32'(pred));
    check("ific_drop", 32'(bus.IFIC_en), 32'd0);
    m_pc = nxt;
    tick();
    check("ifdc_pulse_end", 32'(bus.IFDC_en), 32'd0);
    if (kind == c_JALR) check("jalr_no_fetch", 32'(bus.IFIC_en), 32'd0);
  endtask

  task automatic br_update(input logic [31:0] p, input bit taken);
    bus.ROBIF_br_en    = 1'b1;
    bus.ROBIF_br_pc    = p;
    bus.ROBIF_br_taken = taken;
    model_bht(p, taken);
    tick();
    bus.ROBIF_br_en = 1'b0;
  endtask

  task automatic do_flush(input logic [31:0] tgt);
    bus.ROBIF_flush     = 1'b1;
    bus.ROBIF_target_pc = tgt;
    tick();
    bus.ROBIF_flush = 1'b0;
    check("flush_ific_drop", 32'(bus.IFIC_en), 32'd0);
    check("flush_ifdc_quiet", 32'(bus.IFDC_en), 32'd0);
    m_pc = tgt;
  endtask

  task automatic jalr_resolve(input logic [31:0] tgt, input int delay);
    for (int i = 0; i < delay; i++) begin
      tick();
      check("wait_jalr_no_fetch", 32'(bus.IFIC_en), 32'd0);
    end
    bus.ROBIF_jalr_en = 1'b1;
    bus.ROBIF_jalr_pc = tgt;
    tick();
    bus.ROBIF_jalr_en = 1'b0;
    check("jalr_resolve_idle", 32'(bus.IFIC_en), 32'd0);
    m_pc = tgt;
  endtask

  initial begin
    logic [31:0] a;
    bus.DCIF_ask_IF     = 1'b1;
    bus.ICIF_en         = 1'b0;
    bus.ICIF_data       = 32'h0;
    bus.ROBIF_flush     = 1'b0;
    bus.ROBIF_target_pc = 32'h0;
    bus.ROBIF_jalr_en   = 1'b0;
    bus.ROBIF_jalr_pc   = 32'h0;
    bus.ROBIF_br_en     = 1'b0;
    bus.ROBIF_br_pc     = 32'h0;
    bus.ROBIF_br_taken  = 1'b0;
    model_reset();

    repeat (3) tick();
    check("rst_ific_en", 32'(bus.IFIC_en), 32'd0);
    check("rst_ific_addr", bus.IFIC_addr, 32'd0);
    check("rst_ifdc_en", 32'(bus.IFDC_en), 32'd0);
    check("rst_ifdc_pc", bus.IFDC_pc, 32'd0);
    check("rst_ifdc_opcode", 32'(bus.IFDC_opcode), 32'd0);
    check("rst_ifdc_remain", 32'(bus.IFDC_remain_inst), 32'd0);
    check("rst_ifdc_pred", 32'(bus.IFDC_predict_result), 32'd0);
    rst = 1'b0;

    // Straight-line code, jal, and a branch before/after BHT training.
    do_fetch(32'h00500093, c_ALU, 0, 0, 1'b0, 1'b0);
    check("addi_opcode_const", 32'(bus.IFDC_opcode), 32'h13);
    do_fetch(make_inst(c_ALU, 0, $urandom), c_ALU, 0, 1, 1'b0, 1'b0);
    do_fetch(32'h0100006F, c_JAL, 16, 0, 1'b0, 1'b0);
    check("jal_target_const", m_pc, 32'h18);
    do_fetch(make_inst(c_ALU, 0, $urandom), c_ALU, 0, 0, 1'b0, 1'b0);
    do_fetch(make_inst(c_ALU, 0, $urandom), c_ALU, 0, 2, 1'b0, 1'b0);
    do_fetch(32'hFE000EE3, c_BR, -4, 0, 1'b0, 1'b0);
    br_update(32'h20, 1'b1);
    br_update(32'h20, 1'b1);
    do_flush(32'h20);
    do_fetch(32'hFE000EE3, c_BR, -4, 0, 1'b0, 1'b0);
    check("br_taken_target_const", m_pc, 32'h1C);

    // jalr stall, with a stray cache pulse that must be ignored.
    do_flush(32'h40);
    do_fetch(32'h00008067, c_JALR, 0, 0, 1'b0, 1'b0);
    bus.ICIF_en = 1'b1;
    tick();
    bus.ICIF_en = 1'b0;
    check("wait_jalr_icif_ignored", 32'(bus.IFDC_en), 32'd0);
    jalr_resolve(32'h100, 2);
    do_fetch(make_inst(c_ALU, 0, $urandom), c_ALU, 0, 0, 1'b0, 1'b0);

    // Flush in the cache response cycle.
    wait_ific();
    check("pre_flush_addr", bus.IFIC_addr, m_pc);
    bus.ICIF_en         = 1'b1;
    bus.ICIF_data       = 32'h00500093;
    bus.ROBIF_flush     = 1'b1;
    bus.ROBIF_target_pc = 32'h200;
    tick();
    bus.ICIF_en     = 1'b0;
    bus.ROBIF_flush = 1'b0;
    m_pc = 32'h200;
    check("flush_icif_no_ifdc", 32'(bus.IFDC_en), 32'd0);
    check("flush_icif_ific_drop", 32'(bus.IFIC_en), 32'd0);
    do_fetch(make_inst(c_ALU, 0, $urandom), c_ALU, 0, 0, 1'b0, 1'b0);

    // Flush and jalr resolution in the same cycle.
    do_fetch(make_inst(c_JALR, 0, $urandom), c_JALR, 0, 0, 1'b0, 1'b0);
    bus.ROBIF_flush     = 1'b1;
    bus.ROBIF_target_pc = 32'h200;
    bus.ROBIF_jalr_en   = 1'b1;
    bus.ROBIF_jalr_pc   = 32'h300;
    tick();
    bus.ROBIF_flush   = 1'b0;
    bus.ROBIF_jalr_en = 1'b0;
    m_pc = 32'h200;
    do_fetch(make_inst(c_ALU, 0, $urandom), c_ALU, 0, 0, 1'b0, 1'b0);

    // rdy low mid-fetch: outputs frozen, BHT update dropped.
    wait_ific();
    a = bus.IFIC_addr;
    rdy                = 1'b0;
    bus.ROBIF_br_en    = 1'b1;
    bus.ROBIF_br_pc    = 32'h80;
    bus.ROBIF_br_taken = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      bus.ROBIF_br_en = 1'b0;
      check("rdy_low_ific_en", 32'(bus.IFIC_en), 32'd1);
      check("rdy_low_ific_addr", bus.IFIC_addr, a);
      check("rdy_low_ifdc", 32'(bus.IFDC_en), 32'd0);
    end
    rdy = 1'b1;
    do_fetch(make_inst(c_ALU, 0, $urandom), c_ALU, 0, 0, 1'b0, 1'b0);
    do_flush(32'h80);
    do_fetch(make_inst(c_BR, 8, $urandom), c_BR, 8, 0, 1'b0, 1'b0);

    // Same-cycle lookup and update at one index: lookup sees the old counter.
    do_fetch(make_inst(c_BR, 8, $urandom), c_BR, 8, 0, 1'b1, 1'b1);
    do_flush(32'h84);
    do_fetch(make_inst(c_BR, 8, $urandom), c_BR, 8, 1, 1'b0, 1'b0);
    check("bht_after_same_cycle_update", m_pc, 32'h8C);

    for (int it = 0; it < 80; it++) begin
      int r, k, kind, off;
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        do_flush(32'($urandom_range(0, 1023)) << 2);
      end else if (r <= 2) begin
        br_update(32'($urandom_range(0, 63)) << 2, 1'($urandom_range(0, 1)));
      end else begin
        k    = int'($urandom_range(0, 19));
        kind = (k < 10) ? c_ALU : (k < 13) ? c_JAL : (k < 19) ? c_BR : c_JALR;
        off  = (kind == c_JAL) ? (int'($urandom_range(0, 511)) - 256) * 2
                               : (int'($urandom_range(0, 255)) - 128) * 2;
        do_fetch(make_inst(kind, off, $urandom), kind, off, int'($urandom_range(0, 3)),
                 (kind == c_BR) && ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)));
        if (kind == c_JALR) jalr_resolve(32'($urandom_range(0, 1023)) << 2, int'($urandom_range(0, 2)));
      end
    end

    // Asynchronous reset in the middle of an outstanding fetch.
    br_update(32'h4, 1'b1);
    br_update(32'h4, 1'b1);
    wait_ific();
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_ific_en", 32'(bus.IFIC_en), 32'd0);
    check("async_rst_ific_addr", bus.IFIC_addr, 32'd0);
    bus.ICIF_en   = 1'b1;
    bus.ICIF_data = 32'h00500093;
    tick();
    bus.ICIF_en = 1'b0;
    check("async_rst_no_ifdc", 32'(bus.IFDC_en), 32'd0);
    rst = 1'b0;
    model_reset();
    do_fetch(make_inst(c_ALU, 0, $urandom), c_ALU, 0, 1, 1'b0, 1'b0);
    do_fetch(make_inst(c_BR, 8, $urandom), c_BR, 8, 0, 1'b0, 1'b0);
    check("bht_cleared_by_reset", m_pc, 32'h8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
